// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM with retired-instruction counter.
// Optional feature: define MC_JAL_EN to enable the JAL decode and state.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_control,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9,
    BEQ = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t cur, nxt;
  logic   retire;

  function automatic logic op_known(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ: op_known = 1'b1;
`ifdef MC_JAL_EN
      OP_JAL:                           op_known = 1'b1;
`endif
      default:                          op_known = 1'b0;
    endcase
  endfunction

  // SUB is only reachable from the register-register form.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  alu_dec = sub_ok ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= FETCH;
      instret <= 32'd0;
    end else begin
      cur <= nxt;
      if (retire) instret <= instret + 32'd1;
    end
  end

  assign retire = (cur == MEMWB) || (cur == ALUWB) || (cur == BEQ) ||
                  ((cur == MEMWRITE) && mem_ready);
  assign state  = cur;

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_I:         nxt = EXECI;
          OP_BEQ:       nxt = BEQ;
`ifdef MC_JAL_EN
          OP_JAL:       nxt = JAL;
`endif
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      MEMWB:    nxt = FETCH;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
`ifdef MC_JAL_EN
      JAL:      nxt = ALUWB;
`endif
      default:  nxt = FETCH;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    illegal     = 1'b0;
    case (cur)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = !op_known(opcode);
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec(funct3, opcode[5] & funct7_5);
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(funct3, 1'b0);
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = zero;
      end
`ifdef MC_JAL_EN
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset must silence strobes before the asynchronous state clear settles.
    if (!rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic [31:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .state(state),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got state=%0d, required finish", state);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; opcode = OP_LW; funct3 = 3'b000;
    funct7_5 = 1'b0; zero = 1'b0;
    #12;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state); end
    n_checks++; if (pc_write !== 1'b0 || ir_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got pc=%b ir=%b, required 0 0", pc_write, ir_write); end
    n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %h, required 0", instret); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (pc_write !== 1'b1 || ir_write !== 1'b1) begin n_fail++; $display("FAIL fetch_strobes: got pc=%b ir=%b, required 1 1", pc_write, ir_write); end
    n_checks++; if (alu_src_b !== 2'b10 || result_src !== 2'b10 || adr_src !== 1'b0) begin n_fail++; $display("FAIL fetch_selects: got b=%b res=%b adr=%b, required 10 10 0", alu_src_b, result_src, adr_src); end
  endtask

  task automatic test_lw();
    logic [3:0]  exp_seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [31:0] base = instret;
    opcode = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (state !== exp_seq[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d, required %0d", i, state, exp_seq[i]); end
      n_checks++; if (reg_write !== (exp_seq[i] == 4'd4)) begin n_fail++; $display("FAIL lw_reg_write[%0d]: got %b", i, reg_write); end
      if (exp_seq[i] == 4'd1) begin
        n_checks++; if (alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || imm_src !== 2'b00) begin n_fail++; $display("FAIL lw_decode_sel: got a=%b b=%b imm=%b, required 01 01 00", alu_src_a, alu_src_b, imm_src); end
      end
      if (exp_seq[i] == 4'd2) begin
        n_checks++; if (alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin n_fail++; $display("FAIL lw_memadr_sel: got a=%b b=%b, required 10 01", alu_src_a, alu_src_b); end
      end
      if (exp_seq[i] == 4'd4) begin
        n_checks++; if (result_src !== 2'b01) begin n_fail++; $display("FAIL lw_memwb_res: got %b, required 01", result_src); end
      end
    end
    n_checks++; if (instret !== base + 32'd1) begin n_fail++; $display("FAIL lw_instret: got %h, required %h", instret, base + 32'd1); end
  endtask

  task automatic test_sw_wait();
    logic [31:0] base = instret;
    int writes = 0;
    opcode = OP_SW; mem_ready = 1'b1;
    step(); step(); step();
    n_checks++; if (state !== 4'd5) begin n_fail++; $display("FAIL sw_state: got %0d, required 5", state); end
    n_checks++; if (imm_src !== 2'b01) begin n_fail++; $display("FAIL sw_imm: got %b, required 01", imm_src); end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (mem_write === 1'b1) writes++;
      n_checks++; if (state !== 4'd5 || adr_src !== 1'b1) begin n_fail++; $display("FAIL sw_hold[%0d]: got state=%0d adr=%b, required 5 1", i, state, adr_src); end
      n_checks++; if (instret !== base) begin n_fail++; $display("FAIL sw_early_instret[%0d]: got %h, required %h", i, instret, base); end
      step();
    end
    n_checks++; if (writes != 4) begin n_fail++; $display("FAIL sw_write_cycles: got %0d, required 4", writes); end
    n_checks++; if (state !== 4'd0 || instret !== base + 32'd1) begin n_fail++; $display("FAIL sw_retire: got state=%0d instret=%h, required 0 %h", state, instret, base + 32'd1); end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      logic [31:0] base = instret;
      opcode = OP_BEQ; zero = z[0]; mem_ready = 1'b1;
      step(); step();
      n_checks++; if (state !== 4'd10) begin n_fail++; $display("FAIL beq_state z=%0d: got %0d, required 10", z, state); end
      n_checks++; if (pc_write !== z[0] || alu_control !== 3'b001 || imm_src !== 2'b10) begin n_fail++; $display("FAIL beq_out z=%0d: got pc=%b alu=%b imm=%b, required %0d 001 10", z, pc_write, alu_control, imm_src, z); end
      step();
      n_checks++; if (state !== 4'd0 || instret !== base + 32'd1) begin n_fail++; $display("FAIL beq_end z=%0d: got state=%0d instret=%h, required 0 %h", z, state, instret, base + 32'd1); end
    end
  endtask

  task automatic test_alu();
    logic [6:0] t_op  [6] = '{OP_R, OP_R, OP_I, OP_I, OP_R, OP_R};
    logic [2:0] t_f3  [6] = '{3'b000, 3'b110, 3'b000, 3'b010, 3'b111, 3'b001};
    logic       t_f7  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] t_alu [6] = '{3'b001, 3'b011, 3'b000, 3'b101, 3'b010, 3'b000};
    logic [3:0] t_st  [6] = '{4'd6, 4'd6, 4'd8, 4'd8, 4'd6, 4'd6};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] base = instret;
      opcode = t_op[i]; funct3 = t_f3[i]; funct7_5 = t_f7[i]; mem_ready = 1'b1;
      step(); step();
      n_checks++; if (state !== t_st[i] || alu_control !== t_alu[i]) begin n_fail++; $display("FAIL alu[%0d]: got state=%0d alu=%b, required %0d %b", i, state, alu_control, t_st[i], t_alu[i]); end
      n_checks++; if (alu_src_b !== ((t_st[i] == 4'd8) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL alu_srcb[%0d]: got %b", i, alu_src_b); end
      step();
      n_checks++; if (state !== 4'd7 || reg_write !== 1'b1 || result_src !== 2'b00) begin n_fail++; $display("FAIL aluwb[%0d]: got state=%0d rw=%b res=%b, required 7 1 00", i, state, reg_write, result_src); end
      step();
      n_checks++; if (state !== 4'd0 || instret !== base + 32'd1) begin n_fail++; $display("FAIL alu_end[%0d]: got state=%0d instret=%h, required 0 %h", i, state, instret, base + 32'd1); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] base = instret;
    opcode = 7'b1111111; mem_ready = 1'b1;
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_fetch: got %b, required 0", illegal); end
    step();
    n_checks++; if (state !== 4'd1 || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got state=%0d illegal=%b, required 1 1", state, illegal); end
    step();
    n_checks++; if (state !== 4'd0 || illegal !== 1'b0 || instret !== base) begin n_fail++; $display("FAIL illegal_return: got state=%0d illegal=%b instret=%h, required 0 0 %h", state, illegal, instret, base); end
  endtask

  task automatic test_jal();
    logic [31:0] base = instret;
    opcode = OP_JAL; mem_ready = 1'b1;
    step();
`ifdef MC_JAL_EN
    n_checks++; if (illegal !== 1'b0 || imm_src !== 2'b11) begin n_fail++; $display("FAIL jal_decode: got illegal=%b imm=%b, required 0 11", illegal, imm_src); end
    step();
    n_checks++; if (state !== 4'd9 || pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin n_fail++; $display("FAIL jal_state: got state=%0d pc=%b a=%b b=%b, required 9 1 01 10", state, pc_write, alu_src_a, alu_src_b); end
    step();
    n_checks++; if (state !== 4'd7 || reg_write !== 1'b1) begin n_fail++; $display("FAIL jal_aluwb: got state=%0d rw=%b, required 7 1", state, reg_write); end
    step();
    n_checks++; if (state !== 4'd0 || instret !== base + 32'd1) begin n_fail++; $display("FAIL jal_end: got state=%0d instret=%h, required 0 %h", state, instret, base + 32'd1); end
`else
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL jal_disabled_illegal: got %b, required 1", illegal); end
    step();
    n_checks++; if (state !== 4'd0 || instret !== base) begin n_fail++; $display("FAIL jal_disabled_end: got state=%0d instret=%h, required 0 %h", state, instret, base); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_seq [4] = '{4'd2, 4'd3, 4'd4, 4'd0};
    opcode = OP_LW; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    step(); step();
    n_checks++; if (state !== 4'd3 || adr_src !== 1'b1) begin n_fail++; $display("FAIL memread_wait: got state=%0d adr=%b, required 3 1", state, adr_src); end
    #2;
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    n_checks++; if (state !== 4'd0 || instret !== 32'd0) begin n_fail++; $display("FAIL async_reset: got state=%0d instret=%h, required 0 0", state, instret); end
    n_checks++; if ({pc_write, ir_write, mem_write, reg_write, illegal} !== 5'b0) begin n_fail++; $display("FAIL async_reset_strobes: got %b, required 00000", {pc_write, ir_write, mem_write, reg_write, illegal}); end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL first_fetch: got %0d, required 1", state); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (state !== exp_seq[i]) begin n_fail++; $display("FAIL post_reset_lw[%0d]: got %0d, required %0d", i, state, exp_seq[i]); end
    end
  endtask

  task automatic test_wrap();
    dut.instret = 32'hFFFF_FFFF;
    opcode = OP_BEQ; zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    n_checks++; if (instret !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_hold: got %h, required ffffffff", instret); end
    step();
    n_checks++; if (instret !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap: got %h, required 00000000", instret); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_alu();
    test_illegal();
    test_jal();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
